// File: rtl/fetch_queue_pkg.sv
// -----------------------------------------------------------------------------
// fetch_queue_pkg
// Shared definitions for the fetch/decode decoupling queue. The widths and the
// entry layout are also used by the decode-stage pipeline registers.
//   INSTR_W    : instruction width
//   PC_W       : PC+4 width
//   ENTRY_W    : width of one queue entry {instr, pcn}
//   fq_entry_t : packed entry, instr in the upper half, pcn in the lower half
// -----------------------------------------------------------------------------
package fetch_queue_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;
    localparam int ENTRY_W = INSTR_W + PC_W;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [PC_W-1:0]    pcn;
    } fq_entry_t;

    // Build an entry from the two fetch-stage outputs.
    function automatic fq_entry_t fq_pack(
        input logic [INSTR_W-1:0] instr,
        input logic [PC_W-1:0]    pcn
    );
        fq_entry_t e;
        e.instr = instr;
        e.pcn   = pcn;
        return e;
    endfunction

endpackage

// File: rtl/fq_storage.sv
// -----------------------------------------------------------------------------
// fq_storage
// DEPTH x ENTRY_W register array for the fetch queue: one synchronous write
// port and one asynchronous read port. Contents are not reset; the pointer
// and count logic in fetch_queue decide which entries are meaningful.
// Ports:
//   clk     in   clock
//   wr_en   in   write enable
//   wr_addr in   write address (AW bits)
//   wr_data in   entry to store
//   rd_addr in   read address (AW bits)
//   rd_data out  entry at rd_addr (combinational)
// -----------------------------------------------------------------------------
module fq_storage
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 2
) (
    input  logic               clk,
    input  logic               wr_en,
    input  logic [AW-1:0]      wr_addr,
    input  logic [ENTRY_W-1:0] wr_data,
    input  logic [AW-1:0]      rd_addr,
    output logic [ENTRY_W-1:0] rd_data
);

    logic [ENTRY_W-1:0] mem_q [DEPTH];

    // Synchronous write port.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_data;
        end
    end

    // Asynchronous read port; DEPTH is a power of two so every address is valid.
    assign rd_data = mem_q[rd_addr];

endmodule

// File: rtl/fetch_queue.sv
// -----------------------------------------------------------------------------
// fetch_queue
// Decoupling instruction queue between the IFU and decode. Buffers up to
// DEPTH {instruction, PC+4} pairs; decode stalls back-pressure fetch through
// 'full'. A taken branch/jump consumed at the head ('redirect' with a pop)
// flushes everything except its delay slot.
// Ports:
//   clk       in   clock, all state updates on posedge
//   reset     in   synchronous active-high clear
//   in_valid  in   fetch presents an instruction
//   in_instr  in   fetched instruction
//   in_pcn    in   PC+4 of the fetched instruction
//   full      out  queue holds DEPTH entries
//   out_valid out  queue is not empty
//   out_instr out  head instruction, zero when empty
//   out_pcn   out  head PC+4, zero when empty
//   out_ready in   decode consumes the head
//   redirect  in   head is a taken branch/jump being consumed
// -----------------------------------------------------------------------------
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    input  logic [INSTR_W-1:0] in_instr,
    input  logic [PC_W-1:0]    in_pcn,
    output logic               full,
    output logic               out_valid,
    output logic [INSTR_W-1:0] out_instr,
    output logic [PC_W-1:0]    out_pcn,
    input  logic               out_ready,
    input  logic               redirect
);

    localparam int AW = $clog2(DEPTH);

    localparam logic [AW:0]   CNT_ZERO  = {(AW+1){1'b0}};
    localparam logic [AW:0]   CNT_ONE   = (AW+1)'(1'b1);
    localparam logic [AW:0]   CNT_FULL  = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] PTR_ZERO  = {AW{1'b0}};
    localparam logic [AW-1:0] PTR_ONE   = AW'(1'b1);
    // Truncates naturally to the pointer width (wraps to 0 when DEPTH == 2).
    localparam logic [AW-1:0] PTR_TWO   = AW'(2'd2);

    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0]   count_q,  count_d;

    logic          push_s;
    logic          pop_s;
    logic          take_redirect_s;
    logic          wr_en_s;
    fq_entry_t     wr_entry_s;
    fq_entry_t     head_s;
    logic [ENTRY_W-1:0] rd_data_s;

    // Status is derived from registered state only.
    assign full      = (count_q == CNT_FULL);
    assign out_valid = (count_q != CNT_ZERO);

    // A full queue never accepts a push, even when a pop happens the same cycle.
    assign pop_s           = out_valid & out_ready;
    assign push_s          = in_valid & ~full;
    assign take_redirect_s = pop_s & redirect;

    assign wr_entry_s = fq_pack(in_instr, in_pcn);
    assign head_s     = fq_entry_t'(rd_data_s);

    // Head presentation: zeros when the queue is empty.
    always_comb begin
        out_instr = {INSTR_W{1'b0}};
        out_pcn   = {PC_W{1'b0}};
        if (out_valid) begin
            out_instr = head_s.instr;
            out_pcn   = head_s.pcn;
        end else begin
            out_instr = {INSTR_W{1'b0}};
            out_pcn   = {PC_W{1'b0}};
        end
    end

    // Next-state for pointers, count and the storage write enable.
    always_comb begin
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        wr_en_s  = 1'b0;
        if (reset) begin
            // Registers clear in the sequential block; just suppress the write.
            wr_en_s = 1'b0;
        end else if (take_redirect_s) begin
            if (count_q > CNT_ONE) begin
                // Entries remain after the branch: keep only the delay slot at
                // rd_ptr+1, discard everything behind it and drop any push.
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                wr_ptr_d = rd_ptr_q + PTR_TWO;
                count_d  = CNT_ONE;
                wr_en_s  = 1'b0;
            end else if (push_s) begin
                // Branch was the only entry: the incoming fetch is its delay slot.
                wr_en_s  = 1'b1;
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
                count_d  = CNT_ONE;
            end else begin
                // No delay slot available yet; the queue simply drains.
                rd_ptr_d = rd_ptr_q + PTR_ONE;
                wr_ptr_d = wr_ptr_q;
                count_d  = CNT_ZERO;
                wr_en_s  = 1'b0;
            end
        end else begin
            if (push_s) begin
                wr_en_s  = 1'b1;
                wr_ptr_d = wr_ptr_q + PTR_ONE;
            end else begin
                wr_en_s  = 1'b0;
                wr_ptr_d = wr_ptr_q;
            end
            if (pop_s) begin
                rd_ptr_d = rd_ptr_q + PTR_ONE;
            end else begin
                rd_ptr_d = rd_ptr_q;
            end
            count_d = count_q + (AW+1)'(push_s) - (AW+1)'(pop_s);
        end
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr_q <= PTR_ZERO;
            wr_ptr_q <= PTR_ZERO;
            count_q  <= CNT_ZERO;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    fq_storage #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_storage (
        .clk     (clk),
        .wr_en   (wr_en_s),
        .wr_addr (wr_ptr_q),
        .wr_data (wr_entry_s),
        .rd_addr (rd_ptr_q),
        .rd_data (rd_data_s)
    );

endmodule

// File: tb/tb_fetch_queue.sv
module tb_fetch_queue;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pcn;
    logic        full;
    logic        out_valid;
    logic [31:0] out_instr;
    logic [31:0] out_pcn;
    logic        out_ready;
    logic        redirect;

    int checks = 0;
    int errors = 0;

    // Reference model: ordered list of {instr, pcn}, head at index 0.
    logic [63:0] model_q[$];

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_instr  (in_instr),
        .in_pcn    (in_pcn),
        .full      (full),
        .out_valid (out_valid),
        .out_instr (out_instr),
        .out_pcn   (out_pcn),
        .out_ready (out_ready),
        .redirect  (redirect)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Compare every visible output (and the occupancy) against the model.
    task automatic check_model(input string tag);
        logic [63:0] head;
        int          sz;
        sz   = model_q.size();
        head = (sz != 0) ? model_q[0] : 64'h0;
        check({tag, ".out_valid"}, 32'(out_valid), 32'(sz != 0));
        check({tag, ".full"},      32'(full),      32'(sz == DEPTH));
        check({tag, ".out_instr"}, out_instr,      head[63:32]);
        check({tag, ".out_pcn"},   out_pcn,        head[31:0]);
        check({tag, ".count"},     32'(dut.count_q), 32'(sz));
    endtask

    // Drive one cycle of inputs, advance the model by the queue rules, check.
    task automatic step(input string tag, input logic rst, input logic iv,
                        input logic [31:0] ins, input logic [31:0] pcn,
                        input logic rdy, input logic rd);
        int          sz;
        logic        pop;
        logic        push;
        logic [63:0] keep;
        reset     = rst;
        in_valid  = iv;
        in_instr  = ins;
        in_pcn    = pcn;
        out_ready = rdy;
        redirect  = rd;
        sz   = model_q.size();
        pop  = (sz != 0) && rdy;
        push = iv && (sz != DEPTH);
        @(posedge clk);
        if (rst) begin
            model_q.delete();
        end else if (pop && rd) begin
            if (sz - 1 >= 1) begin
                keep = model_q[1];
                model_q.delete();
                model_q.push_back(keep);
            end else if (push) begin
                model_q.delete();
                model_q.push_back({ins, pcn});
            end else begin
                model_q.delete();
            end
        end else begin
            if (pop) void'(model_q.pop_front());
            if (push) model_q.push_back({ins, pcn});
        end
        @(negedge clk);
        check_model(tag);
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; in_instr = 32'h0; in_pcn = 32'h0;
        out_ready = 1'b0; redirect = 1'b0;
        @(negedge clk);

        // Reset state
        step("rst0", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        check("rst.out_instr", out_instr, 32'h0);

        // Fill three entries without consuming
        step("p11", 1'b0, 1'b1, 32'h11, 32'h3004, 1'b0, 1'b0);
        step("p22", 1'b0, 1'b1, 32'h22, 32'h3008, 1'b0, 1'b0);
        step("p33", 1'b0, 1'b1, 32'h33, 32'h300C, 1'b0, 1'b0);
        check("t1.instr", out_instr, 32'h11);
        check("t1.pcn", out_pcn, 32'h3004);
        check("t1.full", 32'(full), 32'h0);

        // Fill to full, then a blocked push, then a one-cycle pop
        step("p44", 1'b0, 1'b1, 32'h44, 32'h3010, 1'b0, 1'b0);
        check("t2.full_after_44", 32'(full), 32'h1);
        step("p55_blocked", 1'b0, 1'b1, 32'h55, 32'h3014, 1'b0, 1'b0);
        step("pop_full", 1'b0, 1'b1, 32'h55, 32'h3014, 1'b1, 1'b0);
        check("t2.full_dropped", 32'(full), 32'h0);
        check("t2.head_22", out_instr, 32'h22);
        step("p55_accept", 1'b0, 1'b1, 32'h55, 32'h3014, 1'b0, 1'b0);
        check("t2.full_again", 32'(full), 32'h1);

        // Drain, then stream push+pop across a pointer wrap
        for (int i = 0; i < DEPTH; i++)
            step("drain", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        step("p200", 1'b0, 1'b1, 32'h200, 32'h4000, 1'b0, 1'b0);
        check("t3.latency", out_instr, 32'h200);
        for (int i = 1; i <= 10; i++) begin
            step("stream", 1'b0, 1'b1, 32'h200 + 32'(i), 32'h4000 + 32'(4 * i), 1'b1, 1'b0);
            check("t3.stream_head", out_instr, 32'h200 + 32'(i));
        end

        // Redirect with a full queue B,D,X,Y
        step("rstA", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step("pB", 1'b0, 1'b1, 32'hB0, 32'h3100, 1'b0, 1'b0);
        step("pD", 1'b0, 1'b1, 32'hD0, 32'h3104, 1'b0, 1'b0);
        step("pX", 1'b0, 1'b1, 32'hA0, 32'h3108, 1'b0, 1'b0);
        step("pY", 1'b0, 1'b1, 32'hA4, 32'h310C, 1'b0, 1'b0);
        step("redir_full", 1'b0, 1'b1, 32'hE0, 32'h3110, 1'b1, 1'b1);
        check("t4.head_D", out_instr, 32'hD0);
        check("t4.count", 32'(dut.count_q), 32'h1);

        // Redirect with three entries and a live push: push must be dropped
        step("rstB", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step("pB2", 1'b0, 1'b1, 32'hB1, 32'h3200, 1'b0, 1'b0);
        step("pD2", 1'b0, 1'b1, 32'hD1, 32'h3204, 1'b0, 1'b0);
        step("pX2", 1'b0, 1'b1, 32'hA1, 32'h3208, 1'b0, 1'b0);
        step("redir_push", 1'b0, 1'b1, 32'hEE, 32'h320C, 1'b1, 1'b1);
        check("t4b.head_D", out_instr, 32'hD1);
        step("pW", 1'b0, 1'b1, 32'h77, 32'h3300, 1'b0, 1'b0);
        step("popD", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("t4b.next_is_W", out_instr, 32'h77);

        // Redirect when only the branch is queued; delay slot arrives same cycle
        step("rstC", 1'b1, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
        step("pB3", 1'b0, 1'b1, 32'hB2, 32'h30FC, 1'b0, 1'b0);
        step("redir_rem0", 1'b0, 1'b1, 32'hD2, 32'h3100, 1'b1, 1'b1);
        check("t5.head_D", out_instr, 32'hD2);
        step("pT", 1'b0, 1'b1, 32'h99, 32'h3104, 1'b0, 1'b0);
        step("popD3", 1'b0, 1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        check("t5.target_pcn", out_pcn, 32'h3104);

        // Reset while full with redirect and push active
        for (int i = 0; i < DEPTH; i++)
            step("fill", 1'b0, 1'b1, 32'h500 + 32'(i), 32'h5000 + 32'(4 * i), 1'b0, 1'b0);
        step("rst_full", 1'b1, 1'b1, 32'h600, 32'h6000, 1'b1, 1'b1);
        check("t6.out_valid", 32'(out_valid), 32'h0);
        check("t6.full", 32'(full), 32'h0);
        check("t6.out_instr", out_instr, 32'h0);

        // Randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 ($urandom_range(0, 99) < 2),
                 ($urandom_range(0, 99) < 80),
                 $urandom, $urandom,
                 ($urandom_range(0, 99) < 50),
                 ($urandom_range(0, 99) < 20));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Decoupling instruction queue between the fetch stage (IFU) and the decode stage of the pipelined MIPS core. It buffers up to DEPTH fetched {instruction, PC+4} pairs so that decode stalls back-pressure the fetch stage through a single `full` signal. It implements delay-slot-correct flushing when decode resolves a taken branch or jump. The queue replaces the plain F/D pipeline register; fetch-to-decode latency stays at one cycle.

## Interface
- DEPTH, 4, number of entries; power of two, ≥2
- clk  in  1  system clock, all state updates on posedge
- reset  in  1  synchronous, active-high; clears the queue
- in_valid  in  1  the fetch stage presents an instruction this cycle
- in_instr  in  32  fetched instruction (IFU OP output)
- in_pcn  in  32  PC+4 of the fetched instruction (IFU PCn output)
- full  out  1  count == DEPTH; combinational from registered state only
- out_valid  out  1  count != 0
- out_instr  out  32  head instruction; 32'h0 when empty
- out_pcn  out  32  head PC+4; 32'h0 when empty
- out_ready  in  1  decode consumes the head this cycle (decode not stalled)
- redirect  in  1  head is a taken branch/jump being consumed this cycle (the same condition that drives IFU PCsel)

## Operation
- Storage is a circular buffer with rd_ptr, wr_ptr (log2(DEPTH) bits, natural wrap) and count (log2(DEPTH)+1 bits).
- pop = out_valid & out_ready. push = in_valid & ~full. Full state blocks a push even if a pop occurs the same cycle. There is no bypass.
- Normal cycle: the push writes at wr_ptr, the pop advances rd_ptr, and count changes by push − pop.
- redirect is honoured only when pop = 1. Otherwise it is ignored and the queue performs a normal cycle.
- Redirect cycle (delay-slot rule). Let rem = count − 1 after the pop.
  - rem ≥ 1: keep only the entry at rd_ptr+1, which is the delay slot. Discard all other entries and drop any push. Result: count = 1, rd_ptr = old rd_ptr+1, wr_ptr = rd_ptr+1.
  - rem = 0 and push = 1: the pushed entry is the delay slot and is kept. Result: count = 1.
  - rem = 0 and push = 0: the queue becomes empty. The integration guarantees this does not occur, because in_valid is high every non-reset cycle.
- Top-level wiring is fixed: IFU freeze = full & ~redirect, so a redirect is never lost while the queue is full. The instruction fetched in that cycle is dropped per the rem ≥ 1 rule.

## Timing
- Reset values: count = 0, rd_ptr = wr_ptr = 0, full = 0, out_valid = 0, out_instr = 0, out_pcn = 0. Entry contents are don't-care.
- Reset wins over push, pop and redirect in the same cycle. Reset mid-operation empties the queue within one edge.
- Latency: a push at edge N is visible on out_* after edge N. Minimum F→D latency is 1 cycle.
- Throughput is one push and one pop per cycle when 0 < count < DEPTH.
- full deasserts the cycle after a pop from a full queue. A push from the stalled IFU is accepted one cycle later.
- Pointer wrap from DEPTH−1 to 0 must not disturb ordering.

## Structure
- A shared package holds INSTR_W = 32, PC_W = 32 and the entry width ENTRY_W = INSTR_W + PC_W, for reuse by the decode-stage pipeline registers.
- One natural sub-module is fq_storage: a DEPTH×ENTRY_W register array with one synchronous write port and one asynchronous read port.
- Pointer, count and redirect logic stay in fetch_queue.

## Test plan
- Reset, then push instrs 0x11,0x22,0x33 with pcn 0x3004,0x3008,0x300C and out_ready = 0. Response: count = 3, out_instr = 0x11, out_pcn = 0x3004, full = 0.
- Continue pushing 0x44 then 0x55 with out_ready = 0. Response: full = 1 after 0x44 and 0x55 is not accepted. Then pulse out_ready for one cycle: 0x11 leaves, full drops next cycle, and 0x55 is accepted the cycle after.
- Run continuous push and pop for 10 cycles across a pointer wrap. Response: outputs appear in push order, each one cycle after its push, and count is stable.
- Queue holds B(branch),D,X,Y; assert redirect with out_ready. Response: next cycle count = 1, out_instr = D, and the concurrent push is dropped.
- Queue holds only the branch and the same cycle pushes delay slot D; assert redirect. Response: count = 1, out_instr = D. The next push (branch target at pcn 0x3104) appears behind D.
- Assert reset while full with redirect and push active. Response: next cycle out_valid = 0, full = 0, out_instr = 0.
